// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Latency: n/a (definitions only).
// Backpressure: n/a.
//
// Contents: tx serialiser state enum, core_sig request encodings,
// FIFO entry layout and the bit-timer width helper.
package uart_pkg;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   localparam logic [1:0] CORE_SIG_BYTE = 2'b10;
   localparam logic [1:0] CORE_SIG_WORD = 2'b11;
   localparam int         ENTRY_W       = 33;

   // One FIFO entry per request; len=1 means all four bytes of data are sent.
   typedef struct packed {
      logic        len;
      logic [31:0] data;
   } entry_t;

   // The bit timer is never narrower than 11 bits so the default 1042-cycle
   // bit period fits, and grows if a slower baud rate is configured.
   function automatic int bit_timer_w(input int bit_cyc);
      int w;
      w = $clog2(bit_cyc);
      return (w > 11) ? w : 11;
   endfunction

endpackage

// File: rtl/uart_tx_phy.sv
// UART byte serialiser: start bit, 8 data bits LSB first, [even parity], stop bit.
// Latency: txd drops the cycle after a byte is accepted; frame = 10 (11 with parity) bit periods.
// Backpressure: byte_ready_o only in IDLE or on the last cycle of STOP, so bytes chain with no gap.
//
// Optional feature macro: TX_EVEN_PARITY_EN (adds a PARITY bit carrying ^data before STOP).
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   byte_valid_i      byte_data_i holds a byte to send
//   byte_data_i [7:0] byte to send
//   byte_ready_o      byte accepted this cycle when byte_valid_i is high
//   txd_o             serial line, idle high
//   busy_o            a frame is in progress
module uart_tx_phy
   import uart_pkg::*;
#(
   parameter int CLK_PER_HALF_BIT = 521
)
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       byte_valid_i,
   input  logic [7:0] byte_data_i,
   output logic       byte_ready_o,
   output logic       txd_o,
   output logic       busy_o
);

   localparam int                BIT_CYC  = 2 * CLK_PER_HALF_BIT;
   localparam int                TMR_W    = bit_timer_w(BIT_CYC);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(BIT_CYC - 1);

   tx_state_e        state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             bit_end;
   logic             load;
`ifdef TX_EVEN_PARITY_EN
   logic             parity_q, parity_d;
`endif

   assign bit_end = (tmr_q == TMR_LAST);
   assign busy_o  = (state_q != TX_IDLE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= TX_IDLE;
         tmr_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
`ifdef TX_EVEN_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
`ifdef TX_EVEN_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   // txd is decoded straight from the state so a reset drives the line
   // high immediately rather than one clock later.
   always_comb begin
      state_d      = state_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      byte_ready_o = 1'b0;
      txd_o        = 1'b1;
      load         = 1'b0;
`ifdef TX_EVEN_PARITY_EN
      parity_d     = parity_q;
`endif
      // Timer restarts on every bit boundary and stays parked at 0 in IDLE.
      tmr_d = (state_q == TX_IDLE || bit_end) ? '0 : tmr_q + 1'b1;

      case (state_q)
         TX_IDLE: begin
            byte_ready_o = 1'b1;
            load         = byte_valid_i;
         end
         TX_START: begin
            txd_o = 1'b0;
            if (bit_end) begin
               bit_idx_d = '0;
               state_d   = TX_DATA;
            end
         end
         TX_DATA: begin
            txd_o = shift_q[0];
            if (bit_end) begin
               shift_d   = {1'b0, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q == 3'd7) begin
`ifdef TX_EVEN_PARITY_EN
                  state_d = TX_PARITY;
`else
                  state_d = TX_STOP;
`endif
               end
            end
         end
`ifdef TX_EVEN_PARITY_EN
         TX_PARITY: begin
            txd_o = parity_q;
            if (bit_end) state_d = TX_STOP;
         end
`endif
         TX_STOP: begin
            if (bit_end) begin
               // Chain straight into the next start bit when a byte is waiting.
               byte_ready_o = 1'b1;
               if (byte_valid_i) load    = 1'b1;
               else              state_d = TX_IDLE;
            end
         end
         default: state_d = TX_IDLE;
      endcase

      if (load) begin
         shift_d = byte_data_i;
         state_d = TX_START;
`ifdef TX_EVEN_PARITY_EN
         parity_d = ^byte_data_i;
`endif
      end
   end

endmodule

// File: rtl/uart_tx_stream.sv
// Request FIFO plus word-to-byte sequencer feeding a UART serialiser (8N1, 8E1 with TX_EVEN_PARITY_EN).
// Latency: first txd falling edge 2 cycles after the accepting push edge (pop, then START).
// Backpressure: output_stall = request & FIFO full; the core holds its request until accepted.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   send_data [31:0]  payload, byte 0 = send_data[7:0]
//   core_sig  [1:0]   2'b10 push 1 byte, 2'b11 push 4 bytes, 2'b0x idle
//   output_stall      request not accepted this cycle
//   txd               UART serial out, idle high
//   fifo_count        entries queued (0..2**FIFO_AW)
//   tx_busy           serialiser active, byte pending or FIFO non-empty
module uart_tx_stream
   import uart_pkg::*;
#(
   parameter int CLK_PER_HALF_BIT = 521,
   parameter int FIFO_AW          = 6
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        send_data,
   input  logic [1:0]         core_sig,
   output logic               output_stall,
   output logic               txd,
   output logic [FIFO_AW:0]   fifo_count,
   output logic               tx_busy
);

   localparam int DEPTH = 1 << FIFO_AW;

   entry_t           mem_q [DEPTH];
   entry_t           head;
   logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic             full, empty, push, pop;

   logic             seq_vld_q, seq_vld_d;
   logic             seq_len_q, seq_len_d;
   logic [31:0]      seq_word_q, seq_word_d;
   logic [1:0]       byte_idx_q, byte_idx_d;
   logic             seq_last, byte_acc;

   logic             phy_ready, phy_busy;
   logic [7:0]       phy_byte;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign full         = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                         (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
   assign empty        = (wr_ptr_q == rd_ptr_q);
   assign push         = core_sig[1] & ~full;
   // A pop in the same cycle does not clear the stall; the slot frees next cycle.
   assign output_stall = core_sig[1] & full;
   assign fifo_count   = wr_ptr_q - rd_ptr_q;
   assign head         = mem_q[rd_ptr_q[FIFO_AW-1:0]];

   assign phy_byte = seq_word_q[8*byte_idx_q +: 8];
   assign byte_acc = seq_vld_q & phy_ready;
   assign seq_last = ~seq_len_q | (byte_idx_q == 2'd3);
   // The sequencer reloads as soon as its last byte is taken by the serialiser,
   // which keeps consecutive entries gap-free on the line.
   assign pop      = ~empty & (~seq_vld_q | (byte_acc & seq_last));
   assign tx_busy  = phy_busy | seq_vld_q | ~empty;

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= '{len: (core_sig == CORE_SIG_WORD), data: send_data};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         seq_vld_q  <= 1'b0;
         seq_len_q  <= 1'b0;
         seq_word_q <= '0;
         byte_idx_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         seq_vld_q  <= seq_vld_d;
         seq_len_q  <= seq_len_d;
         seq_word_q <= seq_word_d;
         byte_idx_q <= byte_idx_d;
      end
   end

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      seq_vld_d  = seq_vld_q;
      seq_len_d  = seq_len_q;
      seq_word_d = seq_word_q;
      byte_idx_d = byte_idx_q;
      if (byte_acc) begin
         if (seq_last) seq_vld_d  = 1'b0;
         else          byte_idx_d = byte_idx_q + 1'b1;
      end
      if (pop) begin
         seq_vld_d  = 1'b1;
         seq_len_d  = head.len;
         seq_word_d = head.data;
         byte_idx_d = '0;
      end
   end

   uart_tx_phy #(
      .CLK_PER_HALF_BIT (CLK_PER_HALF_BIT)
   ) u_phy (
      .clk_i        (clk),
      .rst_i        (rst),
      .byte_valid_i (seq_vld_q),
      .byte_data_i  (phy_byte),
      .byte_ready_o (phy_ready),
      .txd_o        (txd),
      .busy_o       (phy_busy)
   );

endmodule

// File: tb/tb_uart_tx_stream.sv
module tb_uart_tx_stream;

   localparam int HB  = 4;
   localparam int BIT = 2 * HB;
`ifdef TX_EVEN_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = BIT * NBITS;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] send_data = '0;
   logic [1:0]  core_sig = 2'b00;
   logic        output_stall;
   logic        txd;
   logic [6:0]  fifo_count;
   logic        tx_busy;

   int checks = 0;
   int passed = 0;
   int cyc = 0;
   logic [7:0] exp_q[$];

   uart_tx_stream #(.CLK_PER_HALF_BIT(HB), .FIFO_AW(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .send_data    (send_data),
      .core_sig     (core_sig),
      .output_stall (output_stall),
      .txd          (txd),
      .fifo_count   (fifo_count),
      .tx_busy      (tx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Drive one request, hold it while stalled, record expected bytes on acceptance.
   task automatic push_req(input logic [1:0] sig, input logic [31:0] d);
      int w;
      w = 0;
      @(negedge clk);
      core_sig = sig; send_data = d;
      #1;
      while (output_stall && w < 500) begin
         @(negedge clk); #1; w++;
      end
      checks++;
      if (output_stall) $display("FAIL push_accept: stall=%0b required 0", output_stall);
      else passed++;
      exp_q.push_back(d[7:0]);
      if (sig == 2'b11) begin
         exp_q.push_back(d[15:8]); exp_q.push_back(d[23:16]); exp_q.push_back(d[31:24]);
      end
      @(negedge clk);
      core_sig = 2'b00;
   endtask

   task automatic wait_start(output int sc, output bit ok);
      int w;
      w = 0;
      while (txd !== 1'b0 && w < 3000) begin
         @(negedge clk); w++;
      end
      ok = (txd === 1'b0);
      sc = cyc;
   endtask

   // Receives one frame sampling mid-bit; ok=0 on timeout or framing error.
   task automatic rx_frame(output logic [7:0] b, output logic par, output int sc, output bit ok);
      bit st;
      wait_start(sc, st);
      ok = st; b = '0; par = 1'b0;
      if (st) begin
         repeat (HB) @(negedge clk);
         if (txd !== 1'b0) ok = 0;
         for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge clk);
            b[i] = txd;
         end
`ifdef TX_EVEN_PARITY_EN
         repeat (BIT) @(negedge clk);
         par = txd;
`endif
         repeat (BIT) @(negedge clk);
         if (txd !== 1'b1) ok = 0;
      end
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while (tx_busy !== 1'b0 && w < 8000) begin
         @(negedge clk); w++;
      end
      checks++;
      if (tx_busy !== 1'b0) $display("FAIL drain_timeout: tx_busy=%0b required 0", tx_busy);
      else passed++;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      #12;
      checks++; if (txd !== 1'b1) $display("FAIL rst_txd: got %0b required 1", txd); else passed++;
      checks++; if (output_stall !== 1'b0) $display("FAIL rst_stall: got %0b required 0", output_stall); else passed++;
      checks++; if (fifo_count !== 7'd0) $display("FAIL rst_count: got %0d required 0", fifo_count); else passed++;
      checks++; if (tx_busy !== 1'b0) $display("FAIL rst_busy: got %0b required 0", tx_busy); else passed++;
      core_sig = 2'b10; send_data = 32'hFF;
      @(negedge clk);
      checks++; if (fifo_count !== 7'd0) $display("FAIL rst_no_push: got %0d required 0", fifo_count); else passed++;
      core_sig = 2'b00;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_byte();
      logic [7:0] b;
      logic frame [NBITS];
      push_req(2'b10, 32'h0000_00A5);
      b = exp_q.pop_front();
      frame[0] = 1'b0;
      for (int i = 0; i < 8; i++) frame[1+i] = b[i];
`ifdef TX_EVEN_PARITY_EN
      frame[9] = ^b;
`endif
      frame[NBITS-1] = 1'b1;
      // returned at the negedge after the accepting edge
      checks++; if (txd !== 1'b1) $display("FAIL fall_early0: txd=%0b required 1", txd); else passed++;
      @(negedge clk);
      checks++; if (txd !== 1'b1) $display("FAIL fall_early1: txd=%0b required 1", txd); else passed++;
      @(negedge clk);
      checks++; if (txd !== 1'b0) $display("FAIL fall_at_2: txd=%0b required 0", txd); else passed++;
      for (int k = 0; k < NBITS; k++) begin
         repeat ((k == 0) ? HB : BIT) @(negedge clk);
         checks++;
         if (txd !== frame[k]) $display("FAIL frame_bit%0d: txd=%0b required %0b", k, txd, frame[k]);
         else passed++;
      end
      repeat (HB - 1) @(negedge clk);
      checks++; if (tx_busy !== 1'b1) $display("FAIL busy_last_cycle: got %0b required 1", tx_busy); else passed++;
      @(negedge clk);
      checks++; if (tx_busy !== 1'b0) $display("FAIL busy_after_frame: got %0b required 0", tx_busy); else passed++;
      checks++; if (txd !== 1'b1) $display("FAIL idle_txd: got %0b required 1", txd); else passed++;
      wait_idle();
   endtask

   task automatic test_word();
      logic [7:0] b, e;
      logic par;
      int sc, s0;
      bit ok;
      push_req(2'b11, 32'h4433_2211);
      s0 = 0;
      for (int k = 0; k < 4; k++) begin
         rx_frame(b, par, sc, ok);
         if (k == 0) s0 = sc;
         e = exp_q.pop_front();
         checks++; if (!ok) $display("FAIL word_frame%0d: framing ok=%0b required 1", k, ok); else passed++;
         checks++; if (b !== e) $display("FAIL word_byte%0d: got %02h required %02h", k, b, e); else passed++;
         checks++;
         if (sc - s0 != k * FRAME) $display("FAIL word_spacing%0d: got %0d cycles required %0d", k, sc - s0, k * FRAME);
         else passed++;
      end
      while (tx_busy === 1'b1 && cyc - s0 < 1000) @(negedge clk);
      checks++;
      if (cyc - s0 != 4 * FRAME) $display("FAIL word_total: got %0d cycles required %0d", cyc - s0, 4 * FRAME);
      else passed++;
      wait_idle();
   endtask

   // Fill the FIFO, hold a request through the stall, then drain and compare every byte.
   task automatic test_full_stall();
      int n, pushed, rcvd, sc, stall_cyc, guard;
      bit prod_done, got_stall, cnt_ok, ok;
      logic [7:0] b, e;
      logic par;
      n = 0; pushed = 0; rcvd = 0; prod_done = 0; got_stall = 0; cnt_ok = 1; guard = 0;
      fork
         begin
            while (!got_stall && n < 100) begin
               @(negedge clk);
               core_sig = 2'b10; send_data = {24'h0, 8'(n + 1)};
               #1;
               if (output_stall) got_stall = 1;
               else begin exp_q.push_back(8'(n + 1)); n++; end
            end
            checks++; if (!got_stall) $display("FAIL full_no_stall: stall never seen after %0d pushes", n); else passed++;
            checks++; if (fifo_count !== 7'd64) $display("FAIL full_count: got %0d required 64", fifo_count); else passed++;
            stall_cyc = 0;
            while (output_stall && stall_cyc < 300) begin
               if (fifo_count !== 7'd64) cnt_ok = 0;
               @(negedge clk); #1; stall_cyc++;
            end
            checks++; if (!cnt_ok) $display("FAIL stall_count_held: count left 64 while stalled"); else passed++;
            checks++; if (output_stall) $display("FAIL stall_release: stall=%0b required 0", output_stall); else passed++;
            checks++; if (fifo_count !== 7'd63) $display("FAIL pop_frees: got %0d required 63", fifo_count); else passed++;
            exp_q.push_back(8'(n + 1)); n++;
            @(negedge clk);
            core_sig = 2'b00;
            #1;
            checks++; if (fifo_count !== 7'd64) $display("FAIL held_push: got %0d required 64", fifo_count); else passed++;
            pushed = n;
            prod_done = 1;
         end
         begin
            while (!(prod_done && exp_q.size() == 0) && guard < 200) begin
               rx_frame(b, par, sc, ok);
               guard++;
               e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
               rcvd++;
               checks++;
               if (!ok || b !== e) $display("FAIL full_rx%0d: got %02h ok=%0b required %02h", rcvd, b, ok, e);
               else passed++;
            end
         end
      join
      checks++; if (rcvd != pushed) $display("FAIL full_total: got %0d bytes required %0d", rcvd, pushed); else passed++;
      wait_idle();
   endtask

   task automatic test_reset_midframe();
      int sc, lows;
      bit ok;
      push_req(2'b10, 32'h0000_005A);
      wait_start(sc, ok);
      checks++; if (!ok) $display("FAIL mid_start: no start bit seen"); else passed++;
      repeat (BIT + 2 * BIT + HB) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++; if (txd !== 1'b1) $display("FAIL mid_rst_txd: got %0b required 1", txd); else passed++;
      checks++; if (fifo_count !== 7'd0) $display("FAIL mid_rst_count: got %0d required 0", fifo_count); else passed++;
      checks++; if (tx_busy !== 1'b0) $display("FAIL mid_rst_busy: got %0b required 0", tx_busy); else passed++;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      lows = 0;
      repeat (3 * FRAME) begin
         @(negedge clk);
         if (txd !== 1'b1) lows++;
      end
      checks++; if (lows != 0) $display("FAIL mid_rst_quiet: txd low %0d cycles required 0", lows); else passed++;
      checks++; if (tx_busy !== 1'b0) $display("FAIL mid_rst_idle: tx_busy=%0b required 0", tx_busy); else passed++;
   endtask

`ifdef TX_EVEN_PARITY_EN
   task automatic test_parity();
      logic [7:0] b, e;
      logic par;
      int sc;
      bit ok;
      push_req(2'b10, 32'h0000_0007);
      push_req(2'b10, 32'h0000_0003);
      for (int k = 0; k < 2; k++) begin
         rx_frame(b, par, sc, ok);
         e = exp_q.pop_front();
         checks++;
         if (!ok || b !== e) $display("FAIL par_byte%0d: got %02h required %02h", k, b, e); else passed++;
         checks++;
         if (par !== ^e) $display("FAIL par_bit%0d: got %0b required %0b", k, par, ^e); else passed++;
      end
      wait_idle();
   endtask
`endif

   initial begin
      test_reset();
      test_single_byte();
      test_word();
      test_full_stall();
`ifdef TX_EVEN_PARITY_EN
      test_parity();
`endif
      test_reset_midframe();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
